// File: rtl/dbg_ctrl_pkg.sv
// Shared definitions for the debug freeze controller: state encoding,
// default bus widths and the hard-wired zero register index.
package dbg_ctrl_pkg;

  localparam int unsigned STATE_W        = 3;
  localparam int unsigned REG_ADDR_W_DEF = 5;
  localparam int unsigned DATA_W_DEF     = 32;
  localparam int unsigned ZERO_REG       = 0;
  localparam int unsigned ACCESS_CNT_W   = 16;

  typedef enum logic [STATE_W-1:0] {
    ST_RUN    = 3'd0,
    ST_DRAIN  = 3'd1,
    ST_HALTED = 3'd2,
    ST_ACCESS = 3'd3,
    ST_ACK    = 3'd4
  } dbg_state_e;

  // Pipeline is frozen and empty in these states.
  function automatic logic is_halted_state(input dbg_state_e s);
    return (s == ST_HALTED) || (s == ST_ACCESS) || (s == ST_ACK);
  endfunction

endpackage

// File: rtl/dbg_drain_counter.sv
// Loadable down-counter used to time the pipeline drain; holds while frozen
// and flags terminal count (value 1) combinationally.
module dbg_drain_counter #(
  parameter int unsigned CNT_W = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_freeze,
  output logic             o_tc_c
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (!i_freeze && (r_count != '0)) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_tc_c = (r_count == CNT_W'(1));

endmodule

// File: rtl/dbg_freeze_ctrl.sv
// Debug halt/drain sequencer granting regfile write port and read port A to a
// debug requester. Optional access counter enabled by DBG_ACCESS_COUNT_EN.
module dbg_freeze_ctrl
  import dbg_ctrl_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned REG_ADDR_W   = REG_ADDR_W_DEF,
  parameter int unsigned DATA_W       = DATA_W_DEF
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    dbg_halt_req,
  output logic                    dbg_halted,
  input  logic                    dbg_req,
  input  logic                    dbg_we,
  input  logic [REG_ADDR_W-1:0]   dbg_addr,
  input  logic [DATA_W-1:0]       dbg_wdata,
  output logic                    dbg_ack,
  output logic [DATA_W-1:0]       dbg_rdata,
  output logic                    pipe_hold,
  input  logic                    multdiv_busy,
  output logic                    rf_sel,
  output logic                    rf_we,
  output logic [REG_ADDR_W-1:0]   rf_waddr,
  output logic [DATA_W-1:0]       rf_wdata,
  output logic [REG_ADDR_W-1:0]   rf_raddr,
  input  logic [DATA_W-1:0]       rf_rdata,
  output logic [ACCESS_CNT_W-1:0] dbg_access_count
);

  localparam int unsigned CNT_W = $clog2(DRAIN_CYCLES + 1);

  dbg_state_e            r_state;
  dbg_state_e            w_next_state;

  logic [REG_ADDR_W-1:0] r_addr;
  logic                  r_we;
  logic [DATA_W-1:0]     r_wdata;
  logic [REG_ADDR_W-1:0] w_addr_d;
  logic                  w_we_d;
  logic [DATA_W-1:0]     w_wdata_d;

  logic                  r_pipe_hold;
  logic                  r_halted;
  logic                  r_ack;
  logic                  r_rf_sel;
  logic                  r_rf_we;
  logic [REG_ADDR_W-1:0] r_rf_addr;
  logic [DATA_W-1:0]     r_rf_wdata;
  logic [DATA_W-1:0]     r_rdata;

  logic                  w_pipe_hold_d;
  logic                  w_halted_d;
  logic                  w_ack_d;
  logic                  w_rf_sel_d;
  logic                  w_rf_we_d;
  logic [REG_ADDR_W-1:0] w_rf_addr_d;
  logic [DATA_W-1:0]     w_rf_wdata_d;
  logic [DATA_W-1:0]     w_rdata_d;

  logic                  w_drain_load;
  logic                  w_drain_freeze;
  logic                  w_drain_tc;

  assign w_drain_load   = (r_state == ST_RUN) && dbg_halt_req;
  assign w_drain_freeze = multdiv_busy || (r_state != ST_DRAIN);

  dbg_drain_counter #(
    .CNT_W(CNT_W)
  ) u_drain_counter (
    .clock     (clock),
    .reset     (reset),
    .i_load    (w_drain_load),
    .i_load_val(CNT_W'(DRAIN_CYCLES)),
    .i_freeze  (w_drain_freeze),
    .o_tc_c    (w_drain_tc)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_RUN;
      r_addr     <= '0;
      r_we       <= 1'b0;
      r_wdata    <= '0;
      r_pipe_hold <= 1'b0;
      r_halted   <= 1'b0;
      r_ack      <= 1'b0;
      r_rf_sel   <= 1'b0;
      r_rf_we    <= 1'b0;
      r_rf_addr  <= '0;
      r_rf_wdata <= '0;
      r_rdata    <= '0;
    end else begin
      r_state    <= w_next_state;
      r_addr     <= w_addr_d;
      r_we       <= w_we_d;
      r_wdata    <= w_wdata_d;
      r_pipe_hold <= w_pipe_hold_d;
      r_halted   <= w_halted_d;
      r_ack      <= w_ack_d;
      r_rf_sel   <= w_rf_sel_d;
      r_rf_we    <= w_rf_we_d;
      r_rf_addr  <= w_rf_addr_d;
      r_rf_wdata <= w_rf_wdata_d;
      r_rdata    <= w_rdata_d;
    end
  end

  // Next state plus output values decoded from it, so every output is a flop.
  always_comb begin
    w_next_state = r_state;
    w_addr_d     = r_addr;
    w_we_d       = r_we;
    w_wdata_d    = r_wdata;
    w_rdata_d    = r_rdata;

    case (r_state)
      ST_RUN: begin
        if (dbg_halt_req) w_next_state = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_drain_tc && !multdiv_busy) w_next_state = ST_HALTED;
      end
      ST_HALTED: begin
        if (dbg_req) begin
          w_next_state = ST_ACCESS;
          w_addr_d     = dbg_addr;
          w_we_d       = dbg_we;
          w_wdata_d    = dbg_wdata;
        end else if (!dbg_halt_req) begin
          w_next_state = ST_RUN;
        end
      end
      ST_ACCESS: begin
        w_next_state = ST_ACK;
        if (!r_we) w_rdata_d = rf_rdata;
      end
      ST_ACK: begin
        w_next_state = ST_HALTED;
      end
      default: begin
        w_next_state = ST_RUN;
      end
    endcase

    w_pipe_hold_d = (w_next_state != ST_RUN);
    w_halted_d    = is_halted_state(w_next_state);
    w_ack_d       = (w_next_state == ST_ACK);
    w_rf_sel_d    = (w_next_state == ST_ACCESS);
    // r0 is hard-wired: the access completes but the write is dropped.
    w_rf_we_d     = w_rf_sel_d && w_we_d && (w_addr_d != REG_ADDR_W'(ZERO_REG));
    w_rf_addr_d   = w_rf_sel_d ? w_addr_d : '0;
    w_rf_wdata_d  = w_rf_sel_d ? w_wdata_d : '0;
  end

  assign pipe_hold  = r_pipe_hold;
  assign dbg_halted = r_halted;
  assign dbg_ack    = r_ack;
  assign dbg_rdata  = r_rdata;
  assign rf_sel     = r_rf_sel;
  assign rf_we      = r_rf_we;
  assign rf_waddr   = r_rf_addr;
  assign rf_raddr   = r_rf_addr;
  assign rf_wdata   = r_rf_wdata;

`ifdef DBG_ACCESS_COUNT_EN
  logic [ACCESS_CNT_W-1:0] r_access_count;

  // Counts completed accesses; wraps naturally at the top of the range.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_access_count <= '0;
    end else if (w_next_state == ST_ACK) begin
      r_access_count <= r_access_count + ACCESS_CNT_W'(1);
    end
  end

  assign dbg_access_count = r_access_count;
`else
  assign dbg_access_count = '0;
`endif

endmodule

// File: tb/tb_dbg_freeze_ctrl.sv
// Self-checking bench for dbg_freeze_ctrl: directed halt/access sequences plus
// randomized accesses against a behavioural register-file scoreboard.
`timescale 1ns/1ps
module tb_dbg_freeze_ctrl;

  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 32;
  localparam int unsigned DRAIN = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          dbg_halt_req, dbg_halted, dbg_req, dbg_we, dbg_ack;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata, dbg_rdata;
  logic          pipe_hold, multdiv_busy, rf_sel, rf_we;
  logic [AW-1:0] rf_waddr, rf_raddr;
  logic [DW-1:0] rf_wdata, rf_rdata;
  logic [15:0]   dbg_access_count;

  int n_assert = 0;
  int n_fail   = 0;

  logic [DW-1:0] exp_mem [32];
  logic [DW-1:0] exp_rdata;
  logic [15:0]   exp_count;

  always #5 clock = ~clock;

  dbg_freeze_ctrl #(
    .DRAIN_CYCLES(DRAIN),
    .REG_ADDR_W  (AW),
    .DATA_W      (DW)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .dbg_halt_req    (dbg_halt_req),
    .dbg_halted      (dbg_halted),
    .dbg_req         (dbg_req),
    .dbg_we          (dbg_we),
    .dbg_addr        (dbg_addr),
    .dbg_wdata       (dbg_wdata),
    .dbg_ack         (dbg_ack),
    .dbg_rdata       (dbg_rdata),
    .pipe_hold       (pipe_hold),
    .multdiv_busy    (multdiv_busy),
    .rf_sel          (rf_sel),
    .rf_we           (rf_we),
    .rf_waddr        (rf_waddr),
    .rf_wdata        (rf_wdata),
    .rf_raddr        (rf_raddr),
    .rf_rdata        (rf_rdata),
    .dbg_access_count(dbg_access_count)
  );

  // Environment register file: r0 always reads zero.
  logic [DW-1:0] rf_mem [32];
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) rf_mem[i] <= '0;
    end else if (rf_sel && rf_we) begin
      rf_mem[rf_waddr] <= rf_wdata;
    end
  end
  assign rf_rdata = (rf_raddr == '0) ? '0 : rf_mem[rf_raddr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) exp_mem[i] = '0;
    exp_rdata = '0;
    exp_count = '0;
  endtask

  task automatic model_ack();
`ifdef DBG_ACCESS_COUNT_EN
    exp_count = exp_count + 16'd1;
`endif
  endtask

  // Starts in RUN at a negedge; returns the cycle (edge 0 = first request edge)
  // in which dbg_halted is first expected high.
  task automatic do_halt(input int mode, output int halt_cyc);
    int rem;
    bit b;
    rem = DRAIN;
    halt_cyc = -1;
    dbg_halt_req = 1'b1;
    @(negedge clock);
    for (int c = 1; c <= 60; c++) begin
      check("drain_hold", 32'(pipe_hold), 32'd1);
      check("drain_not_halted", 32'(dbg_halted), 32'd0);
      case (mode)
        1:       b = (c >= 2) && (c <= 4);
        2:       b = (c > 30) ? 1'b0 : 1'($urandom_range(0, 1));
        default: b = 1'b0;
      endcase
      if (mode == 3 && c == 2) dbg_halt_req = 1'b0;
      multdiv_busy = b;
      if (!b) rem--;
      @(negedge clock);
      if (rem == 0) begin
        halt_cyc = c + 1;
        break;
      end
    end
    multdiv_busy = 1'b0;
    check("halted_on", 32'(dbg_halted), 32'd1);
    check("halted_hold", 32'(pipe_hold), 32'd1);
  endtask

  // Starts in HALTED at a negedge; ends at the negedge of the ACK cycle.
  task automatic do_access(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input bit release_now);
    bit wr_eff;
    wr_eff = we && (a != '0);
    dbg_req = 1'b1; dbg_we = we; dbg_addr = a; dbg_wdata = d;
    if (release_now) dbg_halt_req = 1'b0;
    @(negedge clock);
    dbg_req = 1'b0;
    dbg_we = 1'($urandom_range(0, 1));
    dbg_addr = AW'($urandom_range(0, 31));
    dbg_wdata = $urandom;
    check("acc_sel", 32'(rf_sel), 32'd1);
    check("acc_we", 32'(rf_we), 32'(wr_eff));
    check("acc_waddr", 32'(rf_waddr), 32'(a));
    check("acc_raddr", 32'(rf_raddr), 32'(a));
    check("acc_wdata", rf_wdata, d);
    check("acc_no_ack", 32'(dbg_ack), 32'd0);
    if (wr_eff) exp_mem[a] = d;
    if (!we) exp_rdata = (a == '0) ? '0 : exp_mem[a];
    model_ack();
    @(negedge clock);
    check("ack", 32'(dbg_ack), 32'd1);
    check("ack_sel", 32'(rf_sel), 32'd0);
    check("ack_we", 32'(rf_we), 32'd0);
    check("ack_halted", 32'(dbg_halted), 32'd1);
    check("ack_rdata", dbg_rdata, exp_rdata);
    check("ack_count", 32'(dbg_access_count), 32'(exp_count));
  endtask

  task automatic step_halted();
    @(negedge clock);
    check("post_ack_halted", 32'(dbg_halted), 32'd1);
    check("post_ack_no_ack", 32'(dbg_ack), 32'd0);
    check("post_ack_we", 32'(rf_we), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_hold"}, 32'(pipe_hold), 32'd0);
    check({tag, "_halted"}, 32'(dbg_halted), 32'd0);
    check({tag, "_ack"}, 32'(dbg_ack), 32'd0);
    check({tag, "_rdata"}, dbg_rdata, 32'd0);
    check({tag, "_sel"}, 32'(rf_sel), 32'd0);
    check({tag, "_we"}, 32'(rf_we), 32'd0);
    check({tag, "_waddr"}, 32'(rf_waddr), 32'd0);
    check({tag, "_wdata"}, rf_wdata, 32'd0);
    check({tag, "_raddr"}, 32'(rf_raddr), 32'd0);
    check({tag, "_count"}, 32'(dbg_access_count), 32'd0);
  endtask

  initial begin
    int hc;
    bit we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;

    dbg_halt_req = 1'b0; dbg_req = 1'b0; dbg_we = 1'b0;
    dbg_addr = '0; dbg_wdata = '0; multdiv_busy = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    check_all_zero("reset");
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check("run_hold", 32'(pipe_hold), 32'd0);

    // Requests while running are ignored.
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd3; dbg_wdata = 32'd77;
    repeat (3) begin
      @(negedge clock);
      check("run_req_ack", 32'(dbg_ack), 32'd0);
      check("run_req_sel", 32'(rf_sel), 32'd0);
    end
    dbg_req = 1'b0;

    do_halt(0, hc);
    check("halt_cycle_nostall", 32'(hc), 32'd5);

    do_access(1'b1, 5'd12, 32'd8, 1'b0);  step_halted();
    do_access(1'b0, 5'd12, 32'd0, 1'b0);
    check("read_r12", dbg_rdata, 32'd8);  step_halted();

    do_access(1'b1, 5'd0, 32'd55, 1'b0);  step_halted();
    do_access(1'b0, 5'd0, 32'd0, 1'b0);
    check("read_r0", dbg_rdata, 32'd0);   step_halted();

    do_access(1'b1, 5'd4, 32'd30, 1'b0);  step_halted();
    do_access(1'b1, 5'd6, 32'd21, 1'b0);  step_halted();
    // Release in the same cycle as a request: access wins, then resume.
    do_access(1'b0, 5'd4, 32'd0, 1'b1);
    check("read_r4", dbg_rdata, 32'd30);
    @(negedge clock);
    check("rel_halted_cycle_hold", 32'(pipe_hold), 32'd1);
    check("rel_halted_cycle_halted", 32'(dbg_halted), 32'd1);
    @(negedge clock);
    check("rel_run_hold", 32'(pipe_hold), 32'd0);
    check("rel_run_halted", 32'(dbg_halted), 32'd0);
    @(negedge clock);

    do_halt(1, hc);
    check("halt_cycle_stall", 32'(hc), 32'd8);
    do_access(1'b0, 5'd6, 32'd0, 1'b0);
    check("read_r6", dbg_rdata, 32'd21);  step_halted();

    // Release dropped mid-drain: drain still completes, then resume.
    dbg_halt_req = 1'b0;
    @(negedge clock);
    check("resume_hold", 32'(pipe_hold), 32'd0);
    do_halt(3, hc);
    check("halt_cycle_dropped", 32'(hc), 32'd5);
    @(negedge clock);
    check("drop_run_hold", 32'(pipe_hold), 32'd0);
    check("drop_run_halted", 32'(dbg_halted), 32'd0);

    do_halt(2, hc);
    for (int i = 0; i < 32; i++) begin
      we = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom_range(0, 31));
      d  = $urandom;
      do_access(we, a, d, 1'b0);
      step_halted();
      if ((i % 8) == 7) begin
        dbg_halt_req = 1'b0;
        @(negedge clock);
        check("rand_resume_hold", 32'(pipe_hold), 32'd0);
        do_halt(2, hc);
      end
    end

    // Reset in the middle of an access.
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd9; dbg_wdata = 32'd123;
    @(negedge clock);
    dbg_req = 1'b0;
    check("mid_acc_sel", 32'(rf_sel), 32'd1);
    reset = 1'b0;
    dbg_halt_req = 1'b0;
    model_reset();
    #1;
    check_all_zero("mid_reset");
    @(negedge clock);
    check("mid_reset_no_ack", 32'(dbg_ack), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check("post_reset_hold", 32'(pipe_hold), 32'd0);
    check("post_reset_count", 32'(dbg_access_count), 32'(exp_count));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/dbg_freeze_ctrl.md
Name: dbg_freeze_ctrl

Overview:
- Debug/test sequencer for the 5-stage pipeline.
- On request it halts fetch and drains in-flight instructions through writeback.
- While halted, it grants the register file write port and read port A to a debug requester through a req/ack handshake, then resumes the pipeline.
- Sits between the test port and the regfile port mux, beside the hazard/bypass logic.

Parameters:
- DRAIN_CYCLES, 4, cycles after fetch hold before the pipeline is empty (D, X, M, W).
- REG_ADDR_W, 5, register address width.
- DATA_W, 32, register data width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- dbg_halt_req  in  1  level; high requests halt, low requests resume.
- dbg_halted  out  1  high while the pipeline is frozen and empty.
- dbg_req  in  1  access request, sampled only in HALTED.
- dbg_we  in  1  1 = write, 0 = read.
- dbg_addr  in  REG_ADDR_W  target register.
- dbg_wdata  in  DATA_W  write data.
- dbg_ack  out  1  one-cycle completion pulse.
- dbg_rdata  out  DATA_W  read result; holds until the next read completes.
- pipe_hold  out  1  freezes PC and injects nops into F/D.
- multdiv_busy  in  1  multicycle unit has an operation in flight.
- rf_sel  out  1  regfile port mux select; 1 = debug owns the ports.
- rf_we  out  1  regfile write enable (debug side).
- rf_waddr  out  REG_ADDR_W  regfile write address.
- rf_wdata  out  DATA_W  regfile write data.
- rf_raddr  out  REG_ADDR_W  regfile read port A address.
- rf_rdata  in  DATA_W  regfile read port A data; combinational, same cycle.
- dbg_access_count  out  16  see Optional Feature.

Behaviour:
- Reset (reset low, async):
  - state = RUN; drain counter = 0; latched addr/we/wdata = 0.
  - All outputs 0: pipe_hold, dbg_halted, dbg_ack, dbg_rdata, rf_sel, rf_we, rf_waddr, rf_wdata, rf_raddr, dbg_access_count.
- States: RUN, DRAIN, HALTED, ACCESS, ACK. All outputs are decoded from registered state and latches.
- RUN:
  - pipe_hold = 0.
  - dbg_halt_req high at an edge → DRAIN; counter loads DRAIN_CYCLES.
- DRAIN:
  - pipe_hold = 1.
  - Each edge with multdiv_busy = 0 decrements the counter; busy freezes it.
  - Counter == 1 with busy = 0 → HALTED.
  - Unstalled drain lasts exactly DRAIN_CYCLES cycles.
  - Dropping dbg_halt_req mid-drain does not abort; drain completes first.
- HALTED:
  - pipe_hold = 1, dbg_halted = 1.
  - dbg_req = 1 → ACCESS, latching dbg_addr, dbg_we and dbg_wdata. dbg_req has priority over release.
  - dbg_req = 0 and dbg_halt_req = 0 → RUN; pipe_hold falls the following cycle.
- ACCESS (exactly 1 cycle):
  - rf_sel = 1; rf_raddr = rf_waddr = latched addr; rf_wdata = latched wdata.
  - rf_we = latched we AND (addr != 0): writes to r0 are suppressed but still acknowledged.
  - On a read, dbg_rdata captures rf_rdata at the closing edge. A read of r0 returns whatever the regfile drives, which is 0.
  - Next state ACK.
- ACK:
  - dbg_ack = 1, rf_sel = 0, pipe_hold = 1, dbg_halted = 1.
  - Next state HALTED unconditionally.
  - dbg_req still high on the following HALTED cycle starts a new access. Back-to-back accesses cost 3 cycles each (HALTED, ACCESS, ACK).
- Latency:
  - Read/write: request sampled at edge k; ack high in cycle k+2.
  - dbg_rdata is valid when dbg_ack is high.
- Requests outside HALTED are ignored: no ack, no latch.
- dbg_halted deasserts in the same cycle the state leaves HALTED/ACK toward RUN.

Optional Feature:
- Macro: DBG_ACCESS_COUNT_EN.
- Defined:
  - 16-bit counter increments on every ACK cycle, including suppressed r0 writes.
  - Wraps 0xFFFF→0.
  - Cleared only by reset; driven on dbg_access_count.
- Undefined: no counter logic; dbg_access_count tied to 0.

Decomposition:
- Shared package dbg_ctrl_pkg holds:
  - state encoding constants (RUN=0, DRAIN=1, HALTED=2, ACCESS=3, ACK=4, 3 bits);
  - the REG_ADDR_W and DATA_W defaults;
  - the ZERO_REG = 0 constant.
- One sub-module, dbg_drain_counter: loadable down-counter with a freeze input and a terminal-count output.

Test Plan:
- Halt timing: halt_req high at edge 0, multdiv_busy = 0 → pipe_hold high from cycle 1; dbg_halted high from cycle 5; instructions issued before the hold have retired.
- Write then read: write r12 = 8, then read r12 → rf_we pulses 1 cycle with waddr 12; second ack shows dbg_rdata = 8; each ack lands 2 cycles after its req.
- r0 protection: write r0 = 55 → rf_we stays 0 and ack still arrives; read r0 → 0.
- Multdiv stall: halt while multdiv_busy is high for 3 cycles mid-drain → dbg_halted high at cycle 8, not 5.
- Release vs. request: halt_req drops in the same cycle dbg_req rises → access completes first, then RUN; pipe_hold falls after the ack; the program resumes and registers 4 = 30 and 6 = 21 finish correctly.
- Reset mid-access: assert reset during ACCESS → all outputs 0 immediately, no ack, state RUN; with DBG_ACCESS_COUNT_EN defined, the count reads 0.
